// File: rtl/median_pkg.sv
// Shared types and constants for the 3x3 median filter front end.
package median_pkg;

  localparam int PIXEL_W  = 8;
  localparam int WIN_SIDE = 3;

  typedef logic [PIXEL_W-1:0] pixel_t;

  typedef enum logic [1:0] {
    IDLE,
    SEND,
    WAIT
  } state_t;

endpackage

// File: rtl/median_window_feeder_line_buffer.sv
// Single-port line store: combinational read of the old word, write on the clock edge,
// so a read and a write to the same address in one cycle returns the previous contents.
module line_buffer #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 16
) (
  input  logic                     clk_i,
  input  logic                     we_i,
  input  logic [$clog2(DEPTH)-1:0] addr_i,
  input  logic [WIDTH-1:0]         wdata_i,
  output logic [WIDTH-1:0]         rdata_o
);

  logic [WIDTH-1:0] mem_q [DEPTH];

  assign rdata_o = mem_q[addr_i];

  // NOTE: storage arrays are left unreset; their contents are only consumed once
  // two fresh lines have been written after reset or start of frame.
  always_ff @(posedge clk_i) begin
    if (we_i) begin
      mem_q[addr_i] <= wdata_i;
    end
  end

endmodule

// File: rtl/median_window_feeder.sv
// Builds 3x3 neighbourhoods from a raster stream and serialises each interior
// window as a 9-cycle burst, followed by a quiet gap for the median stage.
module median_window_feeder
  import median_pkg::*;
#(
  parameter int WIDTH    = PIXEL_W,
  parameter int IMG_W    = 16,
  parameter int IMG_H    = 16,
  parameter int N_PIXELS = 9,
  parameter int MED_GAP  = 42
) (
  input  logic             CLK,
  input  logic             nRST,
  input  logic [WIDTH-1:0] DI,
  input  logic             DSI,
  input  logic             SOF,
  output logic             RDY,
  output logic [WIDTH-1:0] DO,
  output logic             DSO
);

  localparam int COL_W = $clog2(IMG_W);
  localparam int ROW_W = $clog2(IMG_H);
  localparam int K_W   = $clog2(N_PIXELS);
  localparam int GAP_W = $clog2(MED_GAP + 1);

  localparam logic [COL_W-1:0] COL_LAST  = COL_W'(IMG_W - 1);
  localparam logic [ROW_W-1:0] ROW_LAST  = ROW_W'(IMG_H - 1);
  localparam logic [COL_W-1:0] COL_FIRST = COL_W'(WIN_SIDE - 1);
  localparam logic [ROW_W-1:0] ROW_FIRST = ROW_W'(WIN_SIDE - 1);
  localparam logic [K_W-1:0]   K_LAST    = K_W'(N_PIXELS - 1);
  localparam logic [GAP_W-1:0] GAP_LAST  = GAP_W'(MED_GAP - 1);

  state_t             state_q, state_d;
  logic [COL_W-1:0]   col_q, col_d, cur_col;
  logic [ROW_W-1:0]   row_q, row_d, cur_row;
  logic [K_W-1:0]     k_q, k_d;
  logic [GAP_W-1:0]   gap_q, gap_d;
  logic [WIDTH-1:0]   do_q, do_d;
  logic               dso_q, dso_d;
  logic [WIDTH-1:0]   win_q [N_PIXELS];
  logic [WIDTH-1:0]   win_d [N_PIXELS];
  logic [WIDTH-1:0]   l1_rd, l2_rd;
  logic               accept, win_valid;

  assign RDY    = (state_q == IDLE);
  assign DO     = do_q;
  assign DSO    = dso_q;
  assign accept = DSI && (state_q == IDLE);

  // SOF relocates the accepted pixel to (0,0) before anything is addressed.
  assign cur_col   = SOF ? '0 : col_q;
  assign cur_row   = SOF ? '0 : row_q;
  assign win_valid = accept && (cur_row >= ROW_FIRST) && (cur_col >= COL_FIRST);

  line_buffer #(.WIDTH(WIDTH), .DEPTH(IMG_W)) u_l1 (
    .clk_i   (CLK),
    .we_i    (accept),
    .addr_i  (cur_col),
    .wdata_i (DI),
    .rdata_o (l1_rd)
  );

  line_buffer #(.WIDTH(WIDTH), .DEPTH(IMG_W)) u_l2 (
    .clk_i   (CLK),
    .we_i    (accept),
    .addr_i  (cur_col),
    .wdata_i (l1_rd),
    .rdata_o (l2_rd)
  );

  // NOTE: every signal gets its hold value first so no path leaves it unassigned,
  // which keeps this block purely combinational.
  always_comb begin
    state_d = state_q;
    col_d   = col_q;
    row_d   = row_q;
    k_d     = k_q;
    gap_d   = gap_q;
    do_d    = do_q;
    dso_d   = dso_q;
    win_d   = win_q;

    case (state_q)
      IDLE: begin
        if (accept) begin
          if (cur_col == COL_LAST) begin
            col_d = '0;
            row_d = (cur_row == ROW_LAST) ? '0 : cur_row + 1'b1;
          end else begin
            col_d = cur_col + 1'b1;
            row_d = cur_row;
          end
          for (int r = 0; r < WIN_SIDE; r++) begin
            for (int c = 0; c < WIN_SIDE - 1; c++) begin
              win_d[r*WIN_SIDE + c] = win_q[r*WIN_SIDE + c + 1];
            end
          end
          win_d[WIN_SIDE-1]   = l2_rd;
          win_d[2*WIN_SIDE-1] = l1_rd;
          win_d[N_PIXELS-1]   = DI;
          if (win_valid) begin
            state_d = SEND;
            k_d     = '0;
            dso_d   = 1'b1;
            do_d    = win_d[0];
          end
        end
      end
      SEND: begin
        if (k_q == K_LAST) begin
          state_d = WAIT;
          gap_d   = '0;
          dso_d   = 1'b0;
        end else begin
          k_d  = k_q + 1'b1;
          do_d = win_q[k_d];
        end
      end
      WAIT: begin
        if (gap_q == GAP_LAST) begin
          state_d = IDLE;
        end else begin
          gap_d = gap_q + 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // NOTE: state registers use non-blocking assignments so every flop samples
  // the values from before the edge, independent of block evaluation order.
  always_ff @(posedge CLK) begin
    if (nRST) begin
      state_q <= IDLE;
      col_q   <= '0;
      row_q   <= '0;
      k_q     <= '0;
      gap_q   <= '0;
      do_q    <= '0;
      dso_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      col_q   <= col_d;
      row_q   <= row_d;
      k_q     <= k_d;
      gap_q   <= gap_d;
      do_q    <= do_d;
      dso_q   <= dso_d;
    end
  end

  always_ff @(posedge CLK) begin
    win_q <= win_d;
  end

endmodule

// File: tb/tb_median_window_feeder.sv
// Self-checking bench: random and patterned raster streams compared against an
// image-array reference model; a 3x3 instance feeds a behavioural median.
module tb_median_window_feeder;

  localparam int W   = 4;
  localparam int H   = 4;
  localparam int GAP = 3;

  logic       CLK, nRST;
  logic [7:0] DI, DO;
  logic       DSI, SOF, RDY, DSO;
  logic [7:0] DI3, DO3;
  logic       DSI3, SOF3, RDY3, DSO3;

  int checks = 0;
  int errors = 0;

  median_window_feeder #(.WIDTH(8), .IMG_W(W), .IMG_H(H), .N_PIXELS(9), .MED_GAP(GAP)) u_dut (
    .CLK (CLK), .nRST (nRST), .DI (DI), .DSI (DSI), .SOF (SOF),
    .RDY (RDY), .DO (DO), .DSO (DSO)
  );

  median_window_feeder #(.WIDTH(8), .IMG_W(3), .IMG_H(3), .N_PIXELS(9), .MED_GAP(GAP)) u_dut3 (
    .CLK (CLK), .nRST (nRST), .DI (DI3), .DSI (DSI3), .SOF (SOF3),
    .RDY (RDY3), .DO (DO3), .DSO (DSO3)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  // Reference model: the image as written so far, plus the expected bursts.
  logic [7:0]  img [0:H-1][0:W-1];
  int          mr, mc;
  logic [71:0] exp_q[$];
  logic [71:0] got_q[$];
  int          got_len_q[$];
  logic [71:0] cur_burst = '0;
  int          cur_len = 0;

  // Burst collector for the main instance.
  always @(negedge CLK) begin
    if (DSO === 1'b1) begin
      cur_burst = {cur_burst[63:0], DO};
      cur_len++;
    end else if (cur_len > 0) begin
      got_q.push_back(cur_burst);
      got_len_q.push_back(cur_len);
      cur_len = 0;
    end
  end

  // Behavioural median-stage input capture for the 3x3 instance.
  logic [7:0] med_vals[$];
  int         dso3_pulses = 0;
  logic       dso3_prev = 1'b0;
  always @(negedge CLK) begin
    if (DSO3 === 1'b1) begin
      med_vals.push_back(DO3);
      if (!dso3_prev) dso3_pulses++;
    end
    dso3_prev = (DSO3 === 1'b1);
  end

  task automatic model_reset();
    mr = 0;
    mc = 0;
    exp_q.delete();
  endtask

  task automatic model_accept(input logic [7:0] pix, input logic sof);
    logic [71:0] w;
    if (sof) begin
      mr = 0;
      mc = 0;
    end
    img[mr][mc] = pix;
    if (mr >= 2 && mc >= 2) begin
      w = '0;
      for (int rr = mr - 2; rr <= mr; rr++)
        for (int cc = mc - 2; cc <= mc; cc++)
          w = {w[63:0], img[rr][cc]};
      exp_q.push_back(w);
    end
    mc++;
    if (mc == W) begin
      mc = 0;
      mr = (mr + 1) % H;
    end
  endtask

  // Called at a negedge; holds DSI/DI until the pixel is taken, returns at the
  // negedge right after the accepting edge.
  task automatic drive_pixel(input logic [7:0] pix, input logic sof);
    int budget = 0;
    DI  = pix;
    SOF = sof;
    DSI = 1'b1;
    while (RDY !== 1'b1 && budget < 200) begin
      @(negedge CLK);
      budget++;
    end
    if (RDY !== 1'b1) begin
      checks++;
      errors++;
      $display("FAIL drive_timeout RDY=%b required 1", RDY);
      DSI = 1'b0;
      SOF = 1'b0;
      return;
    end
    @(negedge CLK);
    DSI = 1'b0;
    SOF = 1'b0;
    model_accept(pix, sof);
  endtask

  task automatic do_reset();
    DSI  = 1'b0;
    SOF  = 1'b0;
    nRST = 1'b1;
    @(negedge CLK);
    @(negedge CLK);
    nRST = 1'b0;
    model_reset();
    got_q.delete();
    got_len_q.delete();
  endtask

  task automatic wait_quiet();
    int budget = 0;
    while (!(RDY === 1'b1 && DSO === 1'b0) && budget < 200) begin
      @(negedge CLK);
      budget++;
    end
    checks++;
    if (RDY !== 1'b1) begin
      errors++;
      $display("FAIL quiet_timeout RDY=%b required 1", RDY);
    end
    @(negedge CLK);
    @(negedge CLK);
  endtask

  task automatic test_reset();
    DI = '0; DSI = 1'b0; SOF = 1'b0;
    DI3 = '0; DSI3 = 1'b0; SOF3 = 1'b0;
    nRST = 1'b1;
    @(negedge CLK);
    do_reset();
    checks++;
    if (RDY !== 1'b1) begin errors++; $display("FAIL reset_rdy got %b want 1", RDY); end
    checks++;
    if (DSO !== 1'b0) begin errors++; $display("FAIL reset_dso got %b want 0", DSO); end
    checks++;
    if (DO !== 8'h00) begin errors++; $display("FAIL reset_do got %h want 00", DO); end
    repeat (3) @(negedge CLK);
    checks++;
    if (DSO !== 1'b0 || RDY !== 1'b1) begin
      errors++;
      $display("FAIL reset_idle dso=%b rdy=%b want 0/1", DSO, RDY);
    end
  endtask

  task automatic test_frame();
    int n;
    do_reset();
    for (int i = 0; i < W*H; i++) begin
      drive_pixel(8'((i / W) * 16 + (i % W)), i == 0);
      if (i < 10) begin
        checks++;
        if (DSO !== 1'b0 || got_q.size() != 0) begin
          errors++;
          $display("FAIL early_burst pixel %0d dso=%b bursts=%0d want 0/0", i, DSO, got_q.size());
        end
      end
      if (i == 12) begin
        checks++;
        if (DSO !== 1'b0) begin errors++; $display("FAIL burst_at_col0 dso=%b want 0", DSO); end
      end
      if (i == 10) begin
        checks++;
        if (DSO !== 1'b1 || DO !== 8'h00) begin
          errors++;
          $display("FAIL first_beat dso=%b do=%h want 1/00", DSO, DO);
        end
        n = 0;
        while (DSO === 1'b1 && n < 30) begin n++; @(negedge CLK); end
        checks++;
        if (n != 9) begin errors++; $display("FAIL dso_length got %0d want 9", n); end
        n = 0;
        while (RDY !== 1'b1 && n < 30) begin n++; @(negedge CLK); end
        checks++;
        if (n != GAP) begin errors++; $display("FAIL gap_length got %0d want %0d", n, GAP); end
      end
    end
    wait_quiet();
    checks++;
    if (got_q.size() != 4) begin errors++; $display("FAIL frame_bursts got %0d want 4", got_q.size()); end
    if (got_q.size() >= 1) begin
      checks++;
      if (got_q[0] !== 72'h000102101112202122) begin
        errors++;
        $display("FAIL first_window got %h want 000102101112202122", got_q[0]);
      end
    end
    if (got_q.size() >= 4) begin
      checks++;
      if (got_q[3] !== 72'h111213212223313233) begin
        errors++;
        $display("FAIL last_window got %h want 111213212223313233", got_q[3]);
      end
    end
    for (int i = 0; i < got_q.size() && i < exp_q.size(); i++) begin
      checks++;
      if (got_q[i] !== exp_q[i]) begin errors++; $display("FAIL frame_window %0d got %h want %h", i, got_q[i], exp_q[i]); end
    end
    foreach (got_len_q[i]) begin
      checks++;
      if (got_len_q[i] != 9) begin errors++; $display("FAIL frame_len %0d got %0d want 9", i, got_len_q[i]); end
    end
  endtask

  task automatic test_back_to_back();
    do_reset();
    for (int i = 0; i < 2*W*H; i++) begin
      if ($urandom_range(0, 3) == 0) repeat ($urandom_range(1, 3)) @(negedge CLK);
      drive_pixel(8'($urandom_range(0, 255)), i == 0);
    end
    wait_quiet();
    checks++;
    if (got_q.size() != 8) begin errors++; $display("FAIL b2b_bursts got %0d want 8", got_q.size()); end
    checks++;
    if (got_q.size() != exp_q.size()) begin errors++; $display("FAIL b2b_model_count got %0d want %0d", got_q.size(), exp_q.size()); end
    for (int i = 0; i < got_q.size() && i < exp_q.size(); i++) begin
      checks++;
      if (got_q[i] !== exp_q[i]) begin errors++; $display("FAIL b2b_window %0d got %h want %h", i, got_q[i], exp_q[i]); end
    end
  endtask

  task automatic test_sof();
    int first = -1;
    do_reset();
    for (int i = 0; i < W*H + 7; i++) drive_pixel(8'($urandom_range(0, 255)), i == 0 || i == W*H);
    for (int off = 0; off < W*H; off++) begin
      drive_pixel(8'($urandom_range(0, 255)), off == 0);
      if (DSO === 1'b1 && first < 0) first = off;
    end
    wait_quiet();
    // Offset 10 is the 11th pixel counting the SOF pixel itself.
    checks++;
    if (first != 10) begin errors++; $display("FAIL sof_first_burst got %0d want 10", first); end
    checks++;
    if (got_q.size() != exp_q.size()) begin errors++; $display("FAIL sof_count got %0d want %0d", got_q.size(), exp_q.size()); end
    for (int i = 0; i < got_q.size() && i < exp_q.size(); i++) begin
      checks++;
      if (got_q[i] !== exp_q[i]) begin errors++; $display("FAIL sof_window %0d got %h want %h", i, got_q[i], exp_q[i]); end
    end
  endtask

  task automatic test_reset_mid_burst();
    logic [71:0] e;
    int first = -1;
    int i = 0;
    do_reset();
    while (DSO !== 1'b1 && i < W*H) begin
      drive_pixel(8'($urandom_range(0, 255)), i == 0);
      i++;
    end
    e = (exp_q.size() > 0) ? exp_q[0] : '0;
    repeat (4) @(negedge CLK);
    checks++;
    if (DO !== e[39:32]) begin errors++; $display("FAIL beat4 got %h want %h", DO, e[39:32]); end
    nRST = 1'b1;
    @(negedge CLK);
    nRST = 1'b0;
    checks++;
    if (DSO !== 1'b0 || RDY !== 1'b1) begin
      errors++;
      $display("FAIL abort dso=%b rdy=%b want 0/1", DSO, RDY);
    end
    @(negedge CLK);
    checks++;
    if (got_len_q.size() != 1 || got_len_q[0] != 5) begin
      errors++;
      $display("FAIL partial_len got %0d want 5", (got_len_q.size() > 0) ? got_len_q[0] : -1);
    end
    model_reset();
    got_q.delete();
    got_len_q.delete();
    for (int off = 0; off < W*H; off++) begin
      drive_pixel(8'($urandom_range(0, 255)), 1'b0);
      if (DSO === 1'b1 && first < 0) first = off;
    end
    wait_quiet();
    checks++;
    if (first != 2*W + 2) begin errors++; $display("FAIL post_reset_first got %0d want %0d", first, 2*W + 2); end
    checks++;
    if (got_q.size() != exp_q.size()) begin errors++; $display("FAIL post_reset_count got %0d want %0d", got_q.size(), exp_q.size()); end
    for (int j = 0; j < got_q.size() && j < exp_q.size(); j++) begin
      checks++;
      if (got_q[j] !== exp_q[j]) begin errors++; $display("FAIL post_reset_window %0d got %h want %h", j, got_q[j], exp_q[j]); end
    end
  endtask

  task automatic test_median();
    int budget;
    med_vals.delete();
    dso3_pulses = 0;
    for (int i = 0; i < 9; i++) begin
      DI3  = (i == 4) ? 8'hFF : 8'h80;
      SOF3 = (i == 0);
      DSI3 = 1'b1;
      budget = 0;
      while (RDY3 !== 1'b1 && budget < 200) begin @(negedge CLK); budget++; end
      @(negedge CLK);
      DSI3 = 1'b0;
      SOF3 = 1'b0;
    end
    repeat (20) @(negedge CLK);
    checks++;
    if (dso3_pulses != 1) begin errors++; $display("FAIL median_pulses got %0d want 1", dso3_pulses); end
    checks++;
    if (med_vals.size() != 9) begin errors++; $display("FAIL median_count got %0d want 9", med_vals.size()); end
    if (med_vals.size() == 9) begin
      med_vals.sort();
      checks++;
      if (med_vals[4] !== 8'h80) begin errors++; $display("FAIL median_value got %h want 80", med_vals[4]); end
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_frame();
    test_back_to_back();
    test_sof();
    test_reset_mid_burst();
    test_median();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
